// File: rtl/reg_file_pkg.sv
// Shared types and constants for the pipelined integer register file.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // INIT zeroes the array after reset; RUN is normal operation.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  // LSB of read port `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// An issue sets a bit, a writeback clears it, and set wins on a same-edge collision.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy vector: clear first, then set, so a newer issue overrides a writeback.
  always_comb begin
    busy_d = busy_q;
    if (run_i) begin
      if (clr_en_i && (clr_addr_i != '0)) busy_d[clr_addr_i] = 1'b0;
      if (set_en_i && (set_addr_i != '0)) busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy bits are reset-controlled state.
  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  // Per-port lookup; forced low outside RUN.
  always_comb begin
    busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      busy_o[i] = run_i & busy_q[rd_addr_i[port_lsb(i, AW) +: AW]];
    end
  end

endmodule

// File: rtl/reg_file_pipe.sv
// Integer register file for the pipelined core: NRD combinational read ports
// with write-to-read bypass, one writeback port, a pending-write scoreboard,
// and an INIT sequencer that zeroes the array after every reset.
module reg_file_pipe
  import reg_file_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e        state_q;
  logic [AW-1:0]    idx_q;
  logic             ready_q;
  logic             run;
  logic [XLEN-1:0]  mem_q [NREGS];

  assign run   = (state_q == ST_RUN);
  assign ready = ready_q;

  // Clear sequencer: walk idx from 1 to NREGS-1, then enter RUN with ready registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INIT;
      idx_q   <= AW'(1);
      ready_q <= 1'b0;
    end else if (state_q == ST_INIT) begin
      idx_q <= idx_q + AW'(1);
      if (idx_q == LAST_IDX) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end
  end

  // Array update: zero fill during INIT (x0 on the first edge), writeback in RUN; x0 writes dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == ST_INIT) begin
        mem_q[idx_q] <= '0;
        if (idx_q == AW'(1)) mem_q[0] <= '0;
      end else if (we && (wa != '0)) begin
        mem_q[wa] <= wd;
      end
    end
  end

  // Read ports: x0 and INIT read zero, a same-cycle write to the address is bypassed.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = rd_addr[port_lsb(i, AW) +: AW];
      if (run && (a != '0)) begin
        if (we && (wa == a)) rd_data[port_lsb(i, XLEN) +: XLEN] = wd;
        else                 rd_data[port_lsb(i, XLEN) +: XLEN] = mem_q[a];
      end
    end
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .clr_en_i   (we),
    .clr_addr_i (wa),
    .set_en_i   (iss_valid),
    .set_addr_i (iss_rd),
    .rd_addr_i  (rd_addr),
    .busy_o     (rd_busy)
  );

endmodule
